// File: rtl/tt_pin_serial_rx.sv
// Serial byte receiver on the ui_in pins: SCK=pin0, DATA=pin1, CS_N=pin2, SPI mode 0, MSB first.
// Optional odd-parity framing via `define TT_PIN_SERIAL_RX_PARITY_EN.
module tt_pin_serial_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_pins,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       out_frame_err,
  output logic       out_busy
);

`ifdef TT_PIN_SERIAL_RX_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sck_chain, data_chain, csn_chain;
  logic                   sck_prev;
  logic                   sck_s, data_s, csn_s, rise;

  state_t        state, state_nx;
  logic [3:0]    bitcnt, bitcnt_nx;
  logic [7:0]    shreg, shreg_nx, byte_nx;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic          done, err;

  // Pins 7..3 carry nothing for this block.
  logic unused_pins;
  assign unused_pins = ^in_pins[7:3];

  // Chains load the idle pin levels so reset never looks like a frame start.
  // NOTE: non-blocking assignments in every always_ff so all flops sample pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_chain  <= '0;
      data_chain <= '0;
      csn_chain  <= '1;
      sck_prev   <= 1'b0;
    end else begin
      sck_chain  <= {sck_chain[SYNC_STAGES-2:0],  in_pins[0]};
      data_chain <= {data_chain[SYNC_STAGES-2:0], in_pins[1]};
      csn_chain  <= {csn_chain[SYNC_STAGES-2:0],  in_pins[2]};
      sck_prev   <= sck_chain[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_chain[SYNC_STAGES-1];
  assign data_s = data_chain[SYNC_STAGES-1];
  assign csn_s  = csn_chain[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Priority inside SHIFT: CS_N release, then SCK rise, then timeout.
  // NOTE: every variable written here gets a default first, so no latches are inferred.
  always_comb begin
    state_nx  = state;
    bitcnt_nx = bitcnt;
    shreg_nx  = shreg;
    byte_nx   = shreg;
    tmo_nx    = '0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!csn_s) begin
          state_nx  = SHIFT;
          bitcnt_nx = '0;
        end
      end
      SHIFT: begin
        if (csn_s) begin
          state_nx  = IDLE;
          bitcnt_nx = '0;
          err       = (bitcnt != 4'd0);
        end else if (rise) begin
          if (bitcnt == LAST_BIT) begin
            bitcnt_nx = '0;
`ifdef TT_PIN_SERIAL_RX_PARITY_EN
            byte_nx = shreg;
            done    = ^{shreg, data_s};
            err     = ~(^{shreg, data_s});
`else
            byte_nx = {shreg[6:0], data_s};
            done    = 1'b1;
`endif
          end else begin
            shreg_nx  = {shreg[6:0], data_s};
            bitcnt_nx = bitcnt + 4'd1;
          end
        end else if (TMO_EN && bitcnt != 4'd0) begin
          if (tmo_cnt == TMO_LIMIT) begin
            bitcnt_nx = '0;
            shreg_nx  = '0;
            err       = 1'b1;
          end else begin
            tmo_nx = tmo_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bitcnt        <= '0;
      shreg         <= '0;
      tmo_cnt       <= '0;
      out_byte      <= '0;
      out_valid     <= 1'b0;
      out_frame_err <= 1'b0;
    end else begin
      bitcnt        <= bitcnt_nx;
      shreg         <= shreg_nx;
      tmo_cnt       <= tmo_nx;
      out_valid     <= done;
      out_frame_err <= err;
      if (done) out_byte <= byte_nx;
    end
  end

  always_comb begin
    out_busy = (state == SHIFT);
  end

endmodule

// File: tb/tb_tt_pin_serial_rx.sv
// Directed bench for tt_pin_serial_rx: byte decode, back-to-back, CS_N abort, timeout, reset, parity.
module tb_tt_pin_serial_rx;
  logic       clock = 1'b0;
  logic       reset;
  logic       sck, data, csn;
  logic [7:0] in_pins;
  logic [7:0] out_byte;
  logic       out_valid, out_frame_err, out_busy;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0, err_cnt = 0, both_cnt = 0;
  int exp_valid = 0, exp_err = 0;

  // Unused upper pins carry junk to show they are ignored.
  assign in_pins = {5'b10110, csn, data, sck};

  tt_pin_serial_rx dut (
    .clock        (clock),
    .reset        (reset),
    .in_pins      (in_pins),
    .out_byte     (out_byte),
    .out_valid    (out_valid),
    .out_frame_err(out_frame_err),
    .out_busy     (out_busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (out_valid) valid_cnt++;
    if (out_frame_err) err_cnt++;
    if (out_valid && out_frame_err) both_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    data = b;
    wait_clk(8);
    sck = 1'b1;
    wait_clk(8);
    sck = 1'b0;
  endtask

  task automatic send_bits(input logic [8:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
`ifdef TT_PIN_SERIAL_RX_PARITY_EN
    send_bits({b, ~(^b)}, 9);
`else
    send_bits({1'b0, b}, 8);
`endif
  endtask

  initial begin
    reset = 1'b1; sck = 1'b0; data = 1'b0; csn = 1'b1;
    wait_clk(3);
    check("rst_byte", out_byte, 8'h00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_err", out_frame_err, 1'b0);
    check("rst_busy", out_busy, 1'b0);
    reset = 1'b0;
    wait_clk(100);
    check("idle_busy", out_busy, 1'b0);
    check("idle_byte", out_byte, 8'h00);
    check("idle_valid_cnt", valid_cnt, 0);
    check("idle_err_cnt", err_cnt, 0);

    // SCK activity with CS_N high must be ignored.
    send_bits(9'h0AA, 8);
    wait_clk(8);
    check("cs_high_valid_cnt", valid_cnt, 0);
    check("cs_high_busy", out_busy, 1'b0);

    // Single byte 0xA5.
    csn = 1'b0;
    wait_clk(8);
    check("a5_busy_start", out_busy, 1'b1);
    send_byte(8'hA5);
    exp_valid++;
    check("a5_valid_cnt", valid_cnt, exp_valid);
    check("a5_byte", out_byte, 8'hA5);
    check("a5_busy_after", out_busy, 1'b1);
    csn = 1'b1;
    wait_clk(8);
    check("a5_busy_end", out_busy, 1'b0);
    check("a5_err_cnt", err_cnt, exp_err);

    // Back-to-back 0x3C, 0xFF in one frame.
    csn = 1'b0;
    wait_clk(8);
    send_byte(8'h3C);
    exp_valid++;
    check("b2b_3c_byte", out_byte, 8'h3C);
    check("b2b_3c_cnt", valid_cnt, exp_valid);
    send_byte(8'hFF);
    exp_valid++;
    check("b2b_ff_byte", out_byte, 8'hFF);
    check("b2b_ff_cnt", valid_cnt, exp_valid);
    csn = 1'b1;
    wait_clk(8);
    check("b2b_err_cnt", err_cnt, exp_err);

    // Five bits then CS_N high: frame error, byte held.
    csn = 1'b0;
    wait_clk(8);
    send_bits(9'h015, 5);
    csn = 1'b1;
    wait_clk(8);
    exp_err++;
    check("abort_err_cnt", err_cnt, exp_err);
    check("abort_valid_cnt", valid_cnt, exp_valid);
    check("abort_byte", out_byte, 8'hFF);

    // Three bits then a long idle: exactly one timeout error.
    csn = 1'b0;
    wait_clk(8);
    send_bits(9'h005, 3);
    wait_clk(1100);
    exp_err++;
    check("tmo_err_cnt", err_cnt, exp_err);
    check("tmo_busy", out_busy, 1'b1);
    send_byte(8'h81);
    exp_valid++;
    check("tmo_next_byte", out_byte, 8'h81);
    check("tmo_next_cnt", valid_cnt, exp_valid);
    csn = 1'b1;
    wait_clk(8);
    check("tmo_close_err_cnt", err_cnt, exp_err);

    // Reset in the middle of a byte: no pulses, outputs cleared.
    csn = 1'b0;
    wait_clk(8);
    send_bits(9'h00B, 4);
    reset = 1'b1;
    wait_clk(2);
    check("mid_rst_busy", out_busy, 1'b0);
    check("mid_rst_byte", out_byte, 8'h00);
    reset = 1'b0;
    wait_clk(8);
    check("mid_rst_valid_cnt", valid_cnt, exp_valid);
    check("mid_rst_err_cnt", err_cnt, exp_err);
    send_byte(8'h5A);
    exp_valid++;
    check("post_rst_byte", out_byte, 8'h5A);
    check("post_rst_cnt", valid_cnt, exp_valid);

`ifdef TT_PIN_SERIAL_RX_PARITY_EN
    // 0x07 has three ones: parity bit 1 makes the frame even.
    send_bits({8'h07, 1'b1}, 9);
    exp_err++;
    check("par_bad_err_cnt", err_cnt, exp_err);
    check("par_bad_valid_cnt", valid_cnt, exp_valid);
    check("par_bad_byte", out_byte, 8'h5A);
    send_bits({8'h07, 1'b0}, 9);
    exp_valid++;
    check("par_ok_valid_cnt", valid_cnt, exp_valid);
    check("par_ok_byte", out_byte, 8'h07);
    check("par_ok_err_cnt", err_cnt, exp_err);
`endif

    csn = 1'b1;
    wait_clk(8);
    check("end_busy", out_busy, 1'b0);
    check("never_both", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
